// File: rtl/processor_instr_fetch.sv
// Instruction fetch stage: owns the PC, drives imem, loads the IF/ID register.
// Latency: instruction at PC=A lands in IF/ID one rising edge later; taken branch costs one bubble.
// Backpressure: stall_i freezes PC and IF/ID together; branch and flush are ignored while stalled.
module processor_instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  input  logic        halt_i,
  input  logic [31:0] imem_rdata_i,
  output logic [63:0] imem_addr_o,
  output logic [31:0] instruction_o,
  output logic [63:0] PC_o,
  output logic        valid_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [63:0] pc_plus4;

  // IF/ID pipeline register
  logic [31:0] ir_instr_q;
  logic [31:0] ir_instr_d;
  logic [63:0] ir_pc_q;
  logic [63:0] ir_pc_d;
  logic        ir_valid_q;
  logic        ir_valid_d;

  // Sequential PC increment; wraps modulo 2^64 with no flag.
  assign pc_plus4 = pc_q + 64'd4;

  // State register: reset drops straight back to BOOT from any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BOOT lasts one cycle; HALT is left only via reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = halt_i ? HALT : RUN;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Datapath next values: halt > stall > branch > flush > normal fetch.
  always_comb begin
    pc_d       = pc_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      RUN: begin
        if (halt_i) begin
          // Entering HALT: PC holds, the fetched word is discarded.
          ir_instr_d = NOP_INSTR;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b0;
        end else if (stall_i) begin
          // Hold everything; Decode re-presents any branch next cycle.
          pc_d = pc_q;
        end else if (br_taken_i) begin
          // Redirect and squash the wrong-path word fetched this cycle.
          pc_d       = br_target_i;
          ir_instr_d = NOP_INSTR;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b0;
        end else if (flush_i) begin
          pc_d       = pc_plus4;
          ir_instr_d = NOP_INSTR;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b0;
        end else begin
          pc_d       = pc_plus4;
          ir_instr_d = imem_rdata_i;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
        end
      end
      default: begin
        // BOOT and HALT: PC frozen, IF/ID fed a bubble every cycle.
        ir_instr_d = NOP_INSTR;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // PC and IF/ID registers with asynchronous reset to the boot values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      ir_instr_q <= NOP_INSTR;
      ir_pc_q    <= 64'h0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Outputs are direct register views; imem is addressed straight from the PC.
  always_comb begin
    imem_addr_o   = pc_q;
    instruction_o = ir_instr_q;
    PC_o          = ir_pc_q;
    valid_o       = ir_valid_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_processor_instr_fetch.sv
module tb_processor_instr_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        flush_i;
  logic        br_taken_i;
  logic [63:0] br_target_i;
  logic        halt_i;
  logic [31:0] imem_rdata_i;
  logic [63:0] imem_addr_o;
  logic [31:0] instruction_o;
  logic [63:0] PC_o;
  logic        valid_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  processor_instr_fetch #(
    .RESET_PC (64'h0),
    .NOP_INSTR(32'hD503201F)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .halt_i       (halt_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_addr_o  (imem_addr_o),
    .instruction_o(instruction_o),
    .PC_o         (PC_o),
    .valid_o      (valid_o),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, others tagged with their address.
  always_comb begin
    if (imem_addr_o == 64'h0)      imem_rdata_i = 32'h91000400;
    else if (imem_addr_o == 64'h4) imem_rdata_i = 32'hAB0500E7;
    else                           imem_rdata_i = {16'hE000, imem_addr_o[15:0]};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; br_taken_i = 1'b0;
    br_target_i = 64'h0; halt_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_addr",  imem_addr_o, 64'h0);
    check("rst_instr", {32'h0, instruction_o}, {32'h0, NOP});
    check("rst_pco",   PC_o, 64'h0);
    check("rst_valid", {63'h0, valid_o}, 64'h0);
    check("rst_state", {62'h0, state_o}, 64'h0);
    reset_n = 1'b1;
    #1;
    check("boot_state", {62'h0, state_o}, 64'h0);

    // BOOT -> RUN with a bubble
    tick();
    check("run_state", {62'h0, state_o}, 64'h1);
    check("boot_valid", {63'h0, valid_o}, 64'h0);
    check("boot_addr", imem_addr_o, 64'h0);

    tick();
    check("f0_instr", {32'h0, instruction_o}, 64'h91000400);
    check("f0_pco",   PC_o, 64'h0);
    check("f0_valid", {63'h0, valid_o}, 64'h1);
    tick();
    check("f4_instr", {32'h0, instruction_o}, 64'hAB0500E7);
    check("f4_pco",   PC_o, 64'h4);
    check("f4_addr",  imem_addr_o, 64'h8);

    // Stall three cycles at PC=8; middle cycle also carries branch and flush
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      br_taken_i  = (i == 1);
      flush_i     = (i == 1);
      br_target_i = 64'h80;
      tick();
      check("stall_addr",  imem_addr_o, 64'h8);
      check("stall_instr", {32'h0, instruction_o}, 64'hAB0500E7);
      check("stall_pco",   PC_o, 64'h4);
      check("stall_valid", {63'h0, valid_o}, 64'h1);
    end
    stall_i = 1'b0; br_taken_i = 1'b0; flush_i = 1'b0;
    tick();
    check("f8_instr", {32'h0, instruction_o}, 64'hE0000008);
    check("f8_pco",   PC_o, 64'h8);
    tick();
    check("fc_addr",  imem_addr_o, 64'h10);

    // Branch at PC=0x10 to 0x40
    br_taken_i = 1'b1; br_target_i = 64'h40;
    tick();
    br_taken_i = 1'b0;
    check("br_addr",  imem_addr_o, 64'h40);
    check("br_valid", {63'h0, valid_o}, 64'h0);
    check("br_instr", {32'h0, instruction_o}, {32'h0, NOP});
    check("br_pco",   PC_o, 64'h10);
    tick();
    check("tgt_pco",   PC_o, 64'h40);
    check("tgt_valid", {63'h0, valid_o}, 64'h1);
    check("tgt_instr", {32'h0, instruction_o}, 64'hE0000040);

    // Reach PC=0x20, then flush alone
    br_taken_i = 1'b1; br_target_i = 64'h20;
    tick();
    br_taken_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_addr",  imem_addr_o, 64'h24);
    check("fl_valid", {63'h0, valid_o}, 64'h0);
    check("fl_instr", {32'h0, instruction_o}, {32'h0, NOP});
    check("fl_pco",   PC_o, 64'h20);

    // Asynchronous reset between edges at PC=0x24
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_addr",  imem_addr_o, 64'h0);
    check("arst_valid", {63'h0, valid_o}, 64'h0);
    check("arst_state", {62'h0, state_o}, 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    check("rf_instr", {32'h0, instruction_o}, 64'h91000400);
    check("rf_pco",   PC_o, 64'h0);

    // Wrap: branch to top of address space, one normal fetch
    br_taken_i = 1'b1; br_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_taken_i = 1'b0;
    check("wr_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr",  imem_addr_o, 64'h0);
    check("wrap_pco",   PC_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'h0, instruction_o}, 64'hE000FFFC);

    // Halt, then release halt_i; HALT must persist
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    check("halt_state", {62'h0, state_o}, 64'h2);
    check("halt_valid", {63'h0, valid_o}, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_state", {62'h0, state_o}, 64'h2);
      check("hold_addr",  imem_addr_o, 64'h0);
      check("hold_valid", {63'h0, valid_o}, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
